// File: rtl/me_pkg.sv
// me_pkg: shared definitions for the motion-estimation request sequencer.
//   - sequencer state encoding
//   - core result field widths and result-word field offsets
//   - packed struct holding one captured core result
package me_pkg;

  localparam int MVEC_W       = 10;
  localparam int SAD_W        = 16;
  // res_data = {blk_idx, mvec, sad}; offsets from bit 0
  localparam int RES_SAD_LSB  = 0;
  localparam int RES_MVEC_LSB = SAD_W;
  localparam int RES_IDX_LSB  = SAD_W + MVEC_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_REL  = 3'd2,
    ST_PUSH = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  typedef struct packed {
    logic [MVEC_W-1:0] mvec;
    logic [SAD_W-1:0]  sad;
  } me_res_t;

endpackage

// File: rtl/me_wait_timer.sv
// me_wait_timer: loadable down-counter bounding an ack-edge wait.
//   clk, rst_n    : clock, async active-low reset
//   i_load        : load i_load_val (has priority over counting)
//   i_load_val    : reload value
//   i_en          : decrement while non-zero
//   o_expire      : counter is at zero
module me_wait_timer #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_cnt <= '0;
    else if (i_load)              r_cnt <= i_load_val;
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/me_req_sequencer.sv
// me_req_sequencer: walks NUM_BLK macroblocks through the ME core's
// four-phase req/ack handshake and streams one result word per block.
//   clk, rst_n            : clock, async active-low reset
//   start                 : run trigger, honoured only in IDLE
//   busy, done            : run in progress / one-cycle completion pulse
//   timeout_err           : sticky, set when an ack edge never arrives
//   blk_idx               : current block index (core base address)
//   me_req / me_ack       : four-phase handshake with the core
//   me_min_sad/me_min_mvec: core result, valid while me_ack high
//   res_valid/ready/data  : result stream {blk_idx, mvec, sad}
//   sum_sad               : saturating total of captured SADs this run
module me_req_sequencer
  import me_pkg::*;
#(
  parameter int NUM_BLK = 16,
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 4096,
  parameter int SUM_W   = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          timeout_err,
  output logic [IDX_W-1:0]              blk_idx,
  output logic                          me_req,
  input  logic                          me_ack,
  input  logic [SAD_W-1:0]              me_min_sad,
  input  logic [MVEC_W-1:0]             me_min_mvec,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [IDX_W+MVEC_W+SAD_W-1:0] res_data,
  output logic [SUM_W-1:0]              sum_sad
);

  localparam int                TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_BLK - 1);

  state_t             r_state, w_nxt;
  logic               r_me_req;
  logic               r_err;
  logic [IDX_W-1:0]   r_blk_idx;
  logic [SUM_W-1:0]   r_sum;
  me_res_t            r_res;
  logic               w_expire;
  logic               w_enter;
  logic [SUM_W:0]     w_sum_ext;
  logic [SUM_W-1:0]   w_sum_sat;

  // Timer reloads on every state change, so each wait gets a fresh budget.
  assign w_enter = (w_nxt != r_state);

  me_wait_timer #(.CNT_W(TMR_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_enter),
    .i_load_val (TMR_LOAD),
    .i_en       ((r_state == ST_REQ) || (r_state == ST_REL)),
    .o_expire   (w_expire)
  );

  assign w_sum_ext = {1'b0, r_sum} + (SUM_W+1)'(me_min_sad);
  assign w_sum_sat = w_sum_ext[SUM_W] ? {SUM_W{1'b1}} : w_sum_ext[SUM_W-1:0];

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_nxt = ST_REQ;
      // An arriving ack wins over a same-cycle expiry.
      ST_REQ:  if (me_ack)        w_nxt = ST_REL;
               else if (w_expire) w_nxt = ST_ERR;
      ST_REL:  if (!me_ack)       w_nxt = ST_PUSH;
               else if (w_expire) w_nxt = ST_ERR;
      ST_PUSH: if (res_ready)
                 w_nxt = (r_blk_idx == LAST_IDX) ? ST_DONE : ST_REQ;
      ST_DONE: w_nxt = ST_IDLE;
      ST_ERR:  w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_me_req  <= 1'b0;
      r_err     <= 1'b0;
      r_blk_idx <= '0;
      r_sum     <= '0;
      r_res     <= '0;
    end else begin
      r_state  <= w_nxt;
      // req rises one cycle after REQ entry and drops on the edge that
      // leaves REQ (ack or timeout), giving the idle gap between blocks.
      r_me_req <= (r_state == ST_REQ) && (w_nxt == ST_REQ);
      if (r_state == ST_IDLE && start) begin
        r_blk_idx <= '0;
        r_sum     <= '0;
        r_err     <= 1'b0;
      end
      if (r_state == ST_REQ && me_ack) begin
        r_res.sad  <= me_min_sad;
        r_res.mvec <= me_min_mvec;
        r_sum      <= w_sum_sat;
      end
      if (r_state == ST_PUSH && res_ready && r_blk_idx != LAST_IDX)
        r_blk_idx <= r_blk_idx + 1'b1;
      if (r_state != ST_ERR && w_nxt == ST_ERR)
        r_err <= 1'b1;
    end
  end

  assign busy        = (r_state == ST_REQ) || (r_state == ST_REL) || (r_state == ST_PUSH);
  assign done        = (r_state == ST_DONE);
  assign res_valid   = (r_state == ST_PUSH);
  assign me_req      = r_me_req;
  assign timeout_err = r_err;
  assign blk_idx     = r_blk_idx;
  assign sum_sad     = r_sum;

  assign res_data[RES_IDX_LSB  +: IDX_W]  = r_blk_idx;
  assign res_data[RES_MVEC_LSB +: MVEC_W] = r_res.mvec;
  assign res_data[RES_SAD_LSB  +: SAD_W]  = r_res.sad;

endmodule

// File: tb/tb_me_req_sequencer.sv
// Bench for me_req_sequencer: behavioural ME core responder, a per-cycle
// monitor that compares the result stream against expected words derived
// from the block index, and scenario-level checks (stall, timeout,
// repeated start, mid-run reset, random backpressure).
module tb_me_req_sequencer;

  localparam int NUM_BLK = 4;
  localparam int IDX_W   = 4;
  localparam int TIMEOUT = 32;
  localparam int SUM_W   = 24;
  localparam int DW      = IDX_W + 26;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            busy, done, timeout_err;
  logic [IDX_W-1:0] blk_idx;
  logic            me_req;
  logic            me_ack;
  logic [15:0]     me_min_sad;
  logic [9:0]      me_min_mvec;
  logic            res_valid;
  logic            res_ready;
  logic [DW-1:0]   res_data;
  logic [SUM_W-1:0] sum_sad;

  me_req_sequencer #(
    .NUM_BLK(NUM_BLK), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT), .SUM_W(SUM_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .timeout_err(timeout_err), .blk_idx(blk_idx), .me_req(me_req),
    .me_ack(me_ack), .me_min_sad(me_min_sad), .me_min_mvec(me_min_mvec),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .sum_sad(sum_sad)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cnt, done_cnt, stall_seen, stall_cnt, acc_edge, err_cyc;
  int noack_blk = -1;
  int stall_mode = 0;
  bit err_seen, prev_stall, mon_en;
  logic [DW-1:0] prev_data;
  logic [DW-1:0] words [8];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Expected word for block k: sad=100+k, mvec={h=k, w=3}.
  function automatic logic [DW-1:0] exp_word(input int k);
    logic [4:0] h;
    h = 5'(k);
    return {IDX_W'(k), h, 5'd3, 16'(100 + k)};
  endfunction

  function automatic logic [63:0] exp_sum(input int k);
    int s = 0;
    for (int i = 0; i <= k; i++) s += 100 + i;
    return 64'(s);
  endfunction

  always @(posedge clk) cyc++;

  // ME core model: ack 5 cycles after req rises, drops 2 cycles after req falls.
  int hi_cnt = 0, lo_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (me_req) begin
      hi_cnt++;
      lo_cnt = 0;
      if (hi_cnt == 5 && int'(blk_idx) != noack_blk) begin
        me_ack      = 1'b1;
        me_min_sad  = 16'(100 + int'(blk_idx));
        me_min_mvec = {5'(blk_idx), 5'd3};
      end
    end else begin
      hi_cnt = 0;
      if (me_ack) begin
        lo_cnt++;
        if (lo_cnt == 2) begin
          me_ack = 1'b0;
          lo_cnt = 0;
        end
      end
    end
  end

  // Downstream: always ready, a 7-cycle stall on block 1, or random.
  always @(posedge clk) begin
    #1;
    if (stall_mode == 1 && res_valid && acc_cnt == 1 && stall_cnt < 7) begin
      res_ready = 1'b0;
      stall_cnt++;
    end else if (stall_mode == 2) begin
      res_ready = 1'($urandom_range(0, 1));
    end else begin
      res_ready = 1'b1;
    end
  end

  // Per-cycle compare against the expected stream.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        check("hold_valid", 64'(res_valid), 64'd1);
        check("hold_data", 64'(res_data), 64'(prev_data));
      end
      if (res_valid) begin
        check("res_data", 64'(res_data), 64'(exp_word(acc_cnt)));
        check("sum_sad_live", 64'(sum_sad), exp_sum(acc_cnt));
        check("req_while_valid", 64'(me_req), 64'd0);
      end
      if (me_req) check("blk_idx", 64'(blk_idx), 64'(acc_cnt));
      if (done) begin
        done_cnt++;
        check("busy_at_done", 64'(busy), 64'd0);
      end
      if (timeout_err && !err_seen) begin
        err_seen = 1'b1;
        err_cyc  = cyc;
      end
      if (res_valid && !res_ready) stall_seen++;
      if (res_valid && res_ready) begin
        if (acc_cnt < 8) words[acc_cnt] = res_data;
        if (acc_cnt == 1) acc_edge = cyc + 1;
        acc_cnt++;
      end
      prev_stall = res_valid && !res_ready;
      prev_data  = res_data;
    end
  end

  task automatic clear_model(input int nack, input int smode);
    acc_cnt = 0; done_cnt = 0; stall_seen = 0; stall_cnt = 0;
    err_seen = 0; prev_stall = 0; acc_edge = 0; err_cyc = 0;
    noack_blk = nack; stall_mode = smode;
  endtask

  task automatic do_run(input int nack, input int smode, input bit dbl, input bit exp_err);
    bit fin = 0, dbl_sent = 0;
    clear_model(nack, smode);
    @(negedge clk); #2 start = 1'b1;
    @(negedge clk); #2 start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("err_cleared", 64'(timeout_err), 64'd0);
    for (int i = 0; i < 3000 && !fin; i++) begin
      @(negedge clk); #2;
      if (dbl && !dbl_sent && acc_cnt == 1) begin
        start = 1'b1;
        dbl_sent = 1'b1;
      end else start = 1'b0;
      if (!busy) fin = 1;
    end
    start = 1'b0;
    check("run_terminates", 64'(fin), 64'd1);
    repeat (3) @(negedge clk);
    #2;
    if (exp_err) begin
      check("timeout_err", 64'(timeout_err), 64'd1);
      check("req_after_err", 64'(me_req), 64'd0);
      check("words_before_err", 64'(acc_cnt), 64'd2);
      check("err_latency", 64'(err_cyc - acc_edge), 64'(TIMEOUT));
      check("no_done_on_err", 64'(done_cnt), 64'd0);
    end else begin
      check("word_count", 64'(acc_cnt), 64'(NUM_BLK));
      check("done_pulses", 64'(done_cnt), 64'd1);
      check("sum_final", 64'(sum_sad), 64'd406);
      check("busy_idle", 64'(busy), 64'd0);
      check("no_err", 64'(timeout_err), 64'd0);
    end
  endtask

  initial begin
    bit hit;
    rst_n = 1'b0; start = 1'b0; me_ack = 1'b0; res_ready = 1'b1;
    me_min_sad = '0; me_min_mvec = '0; mon_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_req", 64'(me_req), 64'd0);
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_data", 64'(res_data), 64'd0);
    check("rst_sum", 64'(sum_sad), 64'd0);
    check("rst_err", 64'(timeout_err), 64'd0);
    check("rst_idx", 64'(blk_idx), 64'd0);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;

    // Plain run; literal values pin the expected-word model.
    do_run(-1, 0, 0, 0);
    check("word0_lit", 64'(words[0]), 64'd196708);
    check("word1_lit", 64'(words[1]), 64'd69402725);
    check("word3_lit", 64'(words[3]), 64'd207814759);

    // Seven-cycle backpressure on block 1.
    do_run(-1, 1, 0, 0);
    check("stall_cycles", 64'(stall_seen), 64'd7);

    // Block 2 never acked, then a fresh run clears the flag.
    do_run(2, 0, 0, 1);
    do_run(-1, 0, 0, 0);

    // Extra start mid-run is ignored.
    do_run(-1, 0, 1, 0);

    // Reset while req is up for block 2.
    clear_model(-1, 0);
    @(negedge clk); #2 start = 1'b1;
    @(negedge clk); #2 start = 1'b0;
    hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk); #2;
      if (me_req && blk_idx == 2) hit = 1;
    end
    check("reach_blk2", 64'(hit), 64'd1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_req", 64'(me_req), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_valid", 64'(res_valid), 64'd0);
    check("arst_sum", 64'(sum_sad), 64'd0);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b1;
    prev_stall = 0;
    mon_en = 1'b1;
    do_run(-1, 0, 0, 0);

    // Random backpressure and stray starts.
    for (int r = 0; r < 3; r++) do_run(-1, 2, 1'($urandom_range(0, 1)), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/me_req_sequencer.md
Name: me_req_sequencer

Overview:
- Host-side initiator for the motion-estimation core's req/ack four-phase handshake.
- Steps through NUM_BLK macroblocks in order. For each block it:
  - presents the block index, which the memory wrapper uses as a base address;
  - raises req and waits for ack;
  - captures min_sad and min_mvec;
  - releases req and waits for ack to fall;
  - pushes one result word into a valid/ready stream.
- Sits between the frame-level controller and me_double. Replaces the hand-written req/ack stimulus used in benches.

Parameters:
- NUM_BLK, 16, number of macroblocks per run (≥1).
- IDX_W, 4, width of block index; 2**IDX_W ≥ NUM_BLK.
- TIMEOUT, 4096, max cycles spent waiting for any single ack edge.
- SUM_W, 24, width of the accumulated SAD total.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  one-cycle pulse that begins a run; ignored unless state is IDLE.
- busy  output  1  high from the cycle after an accepted start until return to IDLE.
- done  output  1  one-cycle pulse when the last result has been accepted.
- timeout_err  output  1  sticky error flag; cleared by the next accepted start.
- blk_idx  output  IDX_W  current block index, stable while req is high.
- me_req  output  1  request to core (registered).
- me_ack  input  1  acknowledge from core.
- me_min_sad  input  16  core result SAD, valid while me_ack high.
- me_min_mvec  input  10  core result vector {h[9:5], w[4:0]}, valid while me_ack high.
- res_valid  output  1  result word valid.
- res_ready  input  1  downstream accept.
- res_data  output  IDX_W+26  {blk_idx, mvec[9:0], sad[15:0]}.
- sum_sad  output  SUM_W  running total of captured SADs for the current run.

Behaviour:
- Reset values: every output 0, state IDLE, internal counters 0. Async reset mid-run aborts immediately; me_req drops without waiting for ack.
- FSM states: IDLE, REQ, REL, PUSH, DONE, ERR.
  - IDLE: on start → REQ. Same edge: blk_idx=0, sum_sad=0, timeout_err=0, busy=1.
  - REQ: me_req=1. When me_ack is sampled 1:
    - latch sad and mvec into res_data;
    - sum_sad += sad, saturating at all-ones;
    - me_req goes 0 on the same edge;
    - → REL.
  - REL: me_req=0. When me_ack is sampled 0 → PUSH, with res_valid=1 on the same edge.
  - PUSH: hold res_valid and res_data until res_valid&&res_ready.
    - If blk_idx==NUM_BLK-1 → DONE.
    - Otherwise blk_idx+1 → REQ, with me_req=1 on the following cycle (one idle cycle between consecutive reqs is guaranteed by the REQ entry edge).
  - DONE: done=1 for one cycle, busy=0 → IDLE.
  - ERR: me_req=0, busy=0, timeout_err=1 → IDLE next cycle. No result is pushed for the failing block.
- Timeout: a cycle counter clears on every state entry and counts in REQ and REL. Reaching TIMEOUT-1 with the awaited ack edge still absent → ERR.
- me_ack already high on REQ entry (protocol violation) counts as an ack. The bench must never drive this case; it is defined only for determinism.
- me_ack falling while in REQ before being sampled high: no effect.
- res_ready high outside PUSH: ignored. res_valid never drops before acceptance.
- start during busy: ignored, no state change.
- Handshake latency: req→ack per core. Ack high → res_valid high needs ack-low plus 1 cycle minimum.

Decomposition:
- Shared package me_pkg: state encoding, MVEC_W=10, SAD_W=16, the res_data field offsets.
- One sub-module, me_wait_timer: a loadable down-counter with expire flag, reused in REQ and REL.

Test Plan:
- Behavioural core model: ack 5 cycles after req, drops 2 cycles after req falls, sad=100+idx, mvec={idx[4:0],5'd3}; res_ready tied 1; NUM_BLK=4.
  → four res words, sad 100..103, h=0..3, w=3; sum_sad=406; single done pulse; busy low afterwards.
- Same model with res_ready low for 7 cycles on block 1.
  → res_valid and res_data held stable; me_req not reasserted until acceptance; final sum_sad=406.
- Model never acks block 2, TIMEOUT=32.
  → timeout_err=1 exactly 32 cycles after REQ entry; me_req=0; no res word for idx 2; a new start clears the flag.
- start pulsed again mid-run at block 1.
  → ignored; sequence and results identical to the first scenario.
- rst_n asserted while me_req=1 on block 2.
  → me_req, busy, res_valid and sum_sad are 0 immediately; a restart after ack falls completes a full run of 4 results.
- Real me_double with the standard memory images, NUM_BLK=1.
  → the single result word matches me_double's min_sad and min_mvec as printed by the existing bench.
